core_power_sequencer: RTL and testbench
=======================================

# core_power_sequencer

Sequences the GPU core's clock-gate enable and reset. It sits directly downstream of the scratchpad control registers. It takes the raw software requests for clock enable and reset, and produces `clk_core_en_o`/`rst_n_core_o` that never release reset without a running clock and never gate the clock mid-reset. Its outputs drive the core ICG enable and the core reset tree.

## Interface
- `RST_RELEASE_CYCLES`, default 8: cycles reset is held with clock running before release is allowed.
- `RST_ASSERT_CYCLES`, default 4: minimum cycles reset is held (clock running) after a reset request.
- `IDLE_TIMEOUT`, default 256: maximum drain wait in cycles (only with `CORE_SEQ_IDLE_HS_EN`).
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `clk_en_req_i`, in, 1: requested clock enable (software register bit).
- `rst_n_req_i`, in, 1: requested core reset, active-low (software register bit).
- `core_idle_i`, in, 1: core reports idle. Present only with the macro.
- `clk_core_en_o`, out, 1: ICG enable. Registered. Reset value 0.
- `rst_n_core_o`, out, 1: core reset, active-low. Registered. Reset value 0.
- `busy_o`, out, 1: in a transitional state. Registered. Reset value 0.
- `state_o`, out, 3: current state encoding. Reset value OFF.
- `drain_timeout_o`, out, 1: sticky drain-timeout flag. Present only with the macro. Reset value 0.

## Operation
- Stable states, listed as state (clk, rst_n):
  - OFF (0,0)
  - RST_ON (1,0)
  - RUN (1,1)
  - PAUSE (0,1)
- Transitional states (busy_o=1):
  - RST_REL (1,0)
  - RST_HOLD (1,0)
  - DRAIN (1,1)
- Transitions out of OFF:
  - `clk_en_req_i=1` → RST_REL. Counter loads `RST_RELEASE_CYCLES-1`.
  - Otherwise stay. A reset release without a clock request is ignored.
- RST_REL: decrement the counter. At 0 → RST_ON. Requests are not re-evaluated mid-count.
- Transitions out of RST_ON:
  - `clk_en_req_i=0` → OFF.
  - Else if `rst_n_req_i=1` → RUN.
- Transitions out of RUN:
  - `rst_n_req_i=0` → RST_HOLD. Counter loads `RST_ASSERT_CYCLES-1`. This takes priority over the clock request.
  - Else if `clk_en_req_i=0` → DRAIN with the macro, or PAUSE without it.
- RST_HOLD: decrement the counter. At 0 → RST_ON. RST_ON then reaches OFF if the clock request is 0.
- Transitions out of PAUSE:
  - `rst_n_req_i=0` → RST_HOLD. The clock is re-enabled so reset propagates.
  - Else if `clk_en_req_i=1` → RUN.
- Transitions out of DRAIN:
  - `clk_en_req_i=1` → RUN (abort).
  - Else if `rst_n_req_i=0` → RST_HOLD.
  - Else if `core_idle_i=1` → PAUSE.
  - Else if the timeout counter expires → PAUSE and set `drain_timeout_o`.
- `drain_timeout_o` clears only on entry to RUN from RST_ON, or on `rst_ni`.
- Invariants the outputs must always satisfy:
  - `rst_n_core_o` never changes while `clk_core_en_o=0`.
  - Never (0→1 on `rst_n_core_o`) in the same cycle as a clock change.
- State encodings:
  - OFF=0, RST_REL=1, RST_ON=2, RUN=3, RST_HOLD=4, DRAIN=5, PAUSE=6.
  - 7 is illegal and recovers to OFF on the next edge.

## Timing
- Outputs are decoded from next-state and registered. A request change sampled at edge k changes the outputs at edge k+1.
- RST_REL and RST_HOLD each occupy exactly their parameter's number of cycles.
- From OFF with both requests set at edge 0:
  - `clk_core_en_o` rises at edge 1.
  - RST_ON is reached at edge `RST_RELEASE_CYCLES+1`.
  - `rst_n_core_o` rises at edge `RST_RELEASE_CYCLES+2`.
- Counter width is `$clog2` of the largest parameter plus 1. No wrap: the counter loads on state entry only.
- Asserting `rst_ni` mid-sequence forces OFF, both outputs 0, and `busy_o`=0 asynchronously.
- Parameters must be ≥1. Elaboration fails otherwise.

## Configuration
- `CORE_SEQ_IDLE_HS_EN` defined:
  - DRAIN state, `core_idle_i`, `drain_timeout_o` and the timeout counter exist.
  - RUN→PAUSE waits for core idle.
- `CORE_SEQ_IDLE_HS_EN` undefined:
  - Those ports and the DRAIN state are absent.
  - RUN→PAUSE happens in one cycle.
  - Encoding 5 is illegal.

## Structure
- Package `core_seq_pkg` holds:
  - the `core_seq_state_t` enum (3-bit, encodings above);
  - default parameter constants.
- One sub-module, `core_seq_timer`: a loadable down-counter with `load_i`, `value_i`, `zero_o`. It is used for RST_REL/RST_HOLD and instantiated a second time for the drain timeout under the macro.

## Test plan
- Reset, then `clk_en_req_i=1`, `rst_n_req_i=1` at edge 0 → `clk_core_en_o`=1 at edge 1, `rst_n_core_o`=1 at edge 10, `busy_o`=1 during edges 1–8.
- In RUN, drop `rst_n_req_i` for 1 cycle → `rst_n_core_o`=0 for ≥4 cycles, clock stays 1, then back to RUN.
- In RUN, clear both requests → RST_HOLD for 4 cycles, then RST_ON, then OFF. `rst_n_core_o` falls before `clk_core_en_o`.
- From OFF, set `rst_n_req_i=1` with `clk_en_req_i=0` → outputs stay 0/0 and state stays OFF.
- Macro on, `IDLE_TIMEOUT`=16: RUN, clear `clk_en_req_i` with `core_idle_i`=0 → DRAIN for 16 cycles, then PAUSE with `drain_timeout_o`=1. With `core_idle_i`=1 at cycle 3, PAUSE comes next cycle and the flag stays 0.
- Assert `rst_ni` mid RST_REL → both outputs 0 immediately, `state_o`=0. After release, the sequence restarts fully.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared state encoding, default timing constants and state-to-output decode for the core
// power sequencer. CORE_SEQ_IDLE_HS_EN adds the DRAIN state (encoding 5).
package core_seq_pkg;

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StRstRel  = 3'd1,
        StRstOn   = 3'd2,
        StRun     = 3'd3,
        StRstHold = 3'd4,
`ifdef CORE_SEQ_IDLE_HS_EN
        StDrain   = 3'd5,
`endif
        StPause   = 3'd6
    } core_seq_state_t;

    localparam int unsigned DefRstReleaseCycles = 8;
    localparam int unsigned DefRstAssertCycles  = 4;
    localparam int unsigned DefIdleTimeout      = 256;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic state_clk_en(input core_seq_state_t s);
        return (s != StOff) && (s != StPause);
    endfunction

    function automatic logic state_rst_n(input core_seq_state_t s);
`ifdef CORE_SEQ_IDLE_HS_EN
        return (s == StRun) || (s == StPause) || (s == StDrain);
`else
        return (s == StRun) || (s == StPause);
`endif
    endfunction

    function automatic logic state_busy(input core_seq_state_t s);
`ifdef CORE_SEQ_IDLE_HS_EN
        return (s == StRstRel) || (s == StRstHold) || (s == StDrain);
`else
        return (s == StRstRel) || (s == StRstHold);
`endif
    endfunction

endpackage

// File: rtl/core_seq_timer.sv
// Loadable down-counter: loads value_i on load_i, counts down to zero and holds there.
module core_seq_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_power_sequencer.sv
// Sequences the GPU core ICG enable and core reset from raw software requests.
// Define CORE_SEQ_IDLE_HS_EN to add the idle-handshake DRAIN state and its timeout.
module core_power_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned RST_RELEASE_CYCLES = DefRstReleaseCycles,
    parameter int unsigned RST_ASSERT_CYCLES  = DefRstAssertCycles,
    parameter int unsigned IDLE_TIMEOUT       = DefIdleTimeout
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clk_en_req_i,
    input  logic       rst_n_req_i,
`ifdef CORE_SEQ_IDLE_HS_EN
    input  logic       core_idle_i,
    output logic       drain_timeout_o,
`endif
    output logic       clk_core_en_o,
    output logic       rst_n_core_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam int unsigned CntW = $clog2(max3(RST_RELEASE_CYCLES, RST_ASSERT_CYCLES,
                                               IDLE_TIMEOUT)) + 1;
    localparam logic [CntW-1:0] RelLoad  = CntW'(RST_RELEASE_CYCLES - 1);
    localparam logic [CntW-1:0] AsrtLoad = CntW'(RST_ASSERT_CYCLES - 1);

    if (RST_RELEASE_CYCLES < 1 || RST_ASSERT_CYCLES < 1 || IDLE_TIMEOUT < 1) begin : gen_param_err
        $error("core_power_sequencer: all cycle parameters must be >= 1");
    end

    core_seq_state_t state_q, state_d;
    logic            clk_en_q, rst_n_q, busy_q;
    logic            seq_load, seq_zero;
    logic [CntW-1:0] seq_value;

    core_seq_timer #(
        .Width (CntW)
    ) u_seq_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (seq_load),
        .value_i (seq_value),
        .zero_o  (seq_zero)
    );

`ifdef CORE_SEQ_IDLE_HS_EN
    localparam logic [CntW-1:0] IdleLoad = CntW'(IDLE_TIMEOUT - 1);

    logic drain_load, drain_zero, timeout_set, timeout_clr, timeout_q;

    core_seq_timer #(
        .Width (CntW)
    ) u_drain_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (drain_load),
        .value_i (IdleLoad),
        .zero_o  (drain_zero)
    );
`endif

    always_comb begin
        state_d   = state_q;
        seq_load  = 1'b0;
        seq_value = '0;
`ifdef CORE_SEQ_IDLE_HS_EN
        drain_load  = 1'b0;
        timeout_set = 1'b0;
        timeout_clr = 1'b0;
`endif
        case (state_q)
            StOff: begin
                // A reset release without a clock request is deliberately ignored.
                if (clk_en_req_i) begin
                    state_d   = StRstRel;
                    seq_load  = 1'b1;
                    seq_value = RelLoad;
                end
            end
            StRstRel: begin
                if (seq_zero) state_d = StRstOn;
            end
            StRstOn: begin
                if (!clk_en_req_i) begin
                    state_d = StOff;
                end else if (rst_n_req_i) begin
                    state_d = StRun;
`ifdef CORE_SEQ_IDLE_HS_EN
                    timeout_clr = 1'b1;
`endif
                end
            end
            StRun: begin
                if (!rst_n_req_i) begin
                    state_d   = StRstHold;
                    seq_load  = 1'b1;
                    seq_value = AsrtLoad;
                end else if (!clk_en_req_i) begin
`ifdef CORE_SEQ_IDLE_HS_EN
                    state_d    = StDrain;
                    drain_load = 1'b1;
`else
                    state_d = StPause;
`endif
                end
            end
            StRstHold: begin
                if (seq_zero) state_d = StRstOn;
            end
`ifdef CORE_SEQ_IDLE_HS_EN
            StDrain: begin
                if (clk_en_req_i) begin
                    state_d = StRun;
                end else if (!rst_n_req_i) begin
                    state_d   = StRstHold;
                    seq_load  = 1'b1;
                    seq_value = AsrtLoad;
                end else if (core_idle_i) begin
                    state_d = StPause;
                end else if (drain_zero) begin
                    state_d     = StPause;
                    timeout_set = 1'b1;
                end
            end
`endif
            StPause: begin
                // Clock comes back on with the reset so the reset can propagate.
                if (!rst_n_req_i) begin
                    state_d   = StRstHold;
                    seq_load  = 1'b1;
                    seq_value = AsrtLoad;
                end else if (clk_en_req_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StOff;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StOff;
            clk_en_q <= 1'b0;
            rst_n_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= state_clk_en(state_d);
            rst_n_q  <= state_rst_n(state_d);
            busy_q   <= state_busy(state_d);
        end
    end

`ifdef CORE_SEQ_IDLE_HS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end else if (timeout_clr) begin
            timeout_q <= 1'b0;
        end
    end

    assign drain_timeout_o = timeout_q;
`endif

    assign clk_core_en_o = clk_en_q;
    assign rst_n_core_o  = rst_n_q;
    assign busy_o        = busy_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_core_power_sequencer.sv
// Self-checking bench for core_power_sequencer: cycle model compared on every negedge,
// plus directed scenarios with hand-computed timing expectations.
module tb_core_power_sequencer;

    localparam int unsigned RelC  = 8;
    localparam int unsigned AsrtC = 4;
    localparam int unsigned IdleT = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clk_en_req_i;
    logic       rst_n_req_i;
    logic       core_idle_i;
    logic       clk_core_en_o;
    logic       rst_n_core_o;
    logic       busy_o;
    logic [2:0] state_o;
    logic       drain_timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    core_power_sequencer #(
        .RST_RELEASE_CYCLES (RelC),
        .RST_ASSERT_CYCLES  (AsrtC),
        .IDLE_TIMEOUT       (IdleT)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clk_en_req_i    (clk_en_req_i),
        .rst_n_req_i     (rst_n_req_i),
`ifdef CORE_SEQ_IDLE_HS_EN
        .core_idle_i     (core_idle_i),
        .drain_timeout_o (drain_timeout_o),
`endif
        .clk_core_en_o   (clk_core_en_o),
        .rst_n_core_o    (rst_n_core_o),
        .busy_o          (busy_o),
        .state_o         (state_o)
    );

`ifndef CORE_SEQ_IDLE_HS_EN
    assign drain_timeout_o = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    // Model: state name as its encoding, cycles left in a timed state, sticky timeout flag.
    int m_state = 0;
    int m_left  = 0;
    bit m_flag  = 1'b0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_state <= 0;
            m_left  <= 0;
            m_flag  <= 1'b0;
        end else begin : model_step
            int s;
            int left;
            bit flag;
            s = m_state; left = m_left; flag = m_flag;
            case (m_state)
                0: if (clk_en_req_i) begin s = 1; left = RelC; end
                1, 4: if (left == 1) s = 2; else left = left - 1;
                2: begin
                    if (!clk_en_req_i) s = 0;
                    else if (rst_n_req_i) begin s = 3; flag = 1'b0; end
                end
                3: begin
                    if (!rst_n_req_i) begin s = 4; left = AsrtC; end
`ifdef CORE_SEQ_IDLE_HS_EN
                    else if (!clk_en_req_i) begin s = 5; left = IdleT; end
`else
                    else if (!clk_en_req_i) s = 6;
`endif
                end
                5: begin
                    if (clk_en_req_i) s = 3;
                    else if (!rst_n_req_i) begin s = 4; left = AsrtC; end
                    else if (core_idle_i) s = 6;
                    else if (left == 1) begin s = 6; flag = 1'b1; end
                    else left = left - 1;
                end
                6: begin
                    if (!rst_n_req_i) begin s = 4; left = AsrtC; end
                    else if (clk_en_req_i) s = 3;
                end
                default: s = 0;
            endcase
            m_state <= s;
            m_left  <= left;
            m_flag  <= flag;
        end
    end

    function automatic logic exp_clk(input int s);
        return s inside {1, 2, 3, 4, 5};
    endfunction
    function automatic logic exp_rst(input int s);
        return s inside {3, 5, 6};
    endfunction
    function automatic logic exp_busy(input int s);
        return s inside {1, 4, 5};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Requests are already high; edge 1 is the first edge that sees them in OFF.
    task automatic powerup_seq(input string name);
        for (int e = 1; e <= int'(RelC) + 2; e++) begin
            tick();
            chk({name, "_clk"}, 8'(clk_core_en_o), 8'd1);
            chk({name, "_busy"}, 8'(busy_o), 8'(e <= int'(RelC)));
            chk({name, "_rstn"}, 8'(rst_n_core_o), 8'(e >= int'(RelC) + 2));
            chk({name, "_state"}, 8'(state_o),
                (e <= int'(RelC)) ? 8'd1 : (e == int'(RelC) + 1) ? 8'd2 : 8'd3);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < bound) begin
            tick();
            n++;
        end
        chk(name, 8'(state_o), 8'(s));
    endtask

    logic prev_clk = 1'b0;
    logic prev_rst = 1'b0;

    initial begin
        int low_cnt, rst_fall, clk_fall, n;
        bit clk_drop;

        fork
            forever begin
                @(negedge clk_i);
                if (rst_ni) begin
                    chk("cmp_clk", 8'(clk_core_en_o), 8'(exp_clk(m_state)));
                    chk("cmp_rstn", 8'(rst_n_core_o), 8'(exp_rst(m_state)));
                    chk("cmp_busy", 8'(busy_o), 8'(exp_busy(m_state)));
                    chk("cmp_state", 8'(state_o), 8'(m_state));
`ifdef CORE_SEQ_IDLE_HS_EN
                    chk("cmp_timeout", 8'(drain_timeout_o), 8'(m_flag));
`endif
                    chk("inv_rst_gated",
                        8'(!prev_clk && !clk_core_en_o && (rst_n_core_o != prev_rst)), 8'd0);
                    chk("inv_rel_clkchg",
                        8'(!prev_rst && rst_n_core_o && (clk_core_en_o != prev_clk)), 8'd0);
                    prev_clk = clk_core_en_o;
                    prev_rst = rst_n_core_o;
                end else begin
                    prev_clk = 1'b0;
                    prev_rst = 1'b0;
                end
            end
        join_none

        rst_ni = 1'b0; clk_en_req_i = 1'b0; rst_n_req_i = 1'b0; core_idle_i = 1'b0;
        repeat (3) tick();
        chk("reset_clk", 8'(clk_core_en_o), 8'd0);
        chk("reset_rstn", 8'(rst_n_core_o), 8'd0);
        chk("reset_busy", 8'(busy_o), 8'd0);
        chk("reset_state", 8'(state_o), 8'd0);
        chk("reset_timeout", 8'(drain_timeout_o), 8'd0);
        chk("model_pin_reset", 8'(m_state), 8'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Power-up from OFF with both requests.
        tick();
        clk_en_req_i = 1'b1; rst_n_req_i = 1'b1;
        powerup_seq("pwr");
        chk("model_pin_run", 8'(m_state), 8'd3);

        // One-cycle reset pulse from RUN.
        rst_n_req_i = 1'b0;
        tick();
        rst_n_req_i = 1'b1;
        low_cnt = 0; clk_drop = 1'b0; n = 0;
        while (state_o !== 3'd3 && n < 30) begin
            if (rst_n_core_o == 1'b0) low_cnt++;
            if (clk_core_en_o == 1'b0) clk_drop = 1'b1;
            tick();
            n++;
        end
        chk("pulse_low_cycles", 8'(low_cnt), 8'(AsrtC + 1));
        chk("pulse_clk_held", 8'(clk_drop), 8'd0);
        chk("pulse_back_run", 8'(state_o), 8'd3);

        // Drop both requests: reset falls first, clock falls after HOLD and RST_ON.
        clk_en_req_i = 1'b0; rst_n_req_i = 1'b0;
        rst_fall = 0; clk_fall = 0;
        for (int e = 1; e <= int'(AsrtC) + 3; e++) begin
            tick();
            if (rst_fall == 0 && !rst_n_core_o) rst_fall = e;
            if (clk_fall == 0 && !clk_core_en_o) clk_fall = e;
        end
        chk("off_rst_fall_edge", 8'(rst_fall), 8'd1);
        chk("off_clk_fall_edge", 8'(clk_fall), 8'(AsrtC + 2));
        chk("off_state", 8'(state_o), 8'd0);
        chk("model_pin_off", 8'(m_state), 8'd0);

        // Reset release without clock request is ignored.
        rst_n_req_i = 1'b1;
        repeat (8) begin
            tick();
            chk("norel_clk", 8'(clk_core_en_o), 8'd0);
            chk("norel_rstn", 8'(rst_n_core_o), 8'd0);
            chk("norel_state", 8'(state_o), 8'd0);
        end

        clk_en_req_i = 1'b1;
        powerup_seq("pwr2");

`ifndef CORE_SEQ_IDLE_HS_EN
        // RUN -> PAUSE in one cycle, then reset from PAUSE re-enables the clock.
        clk_en_req_i = 1'b0;
        tick();
        chk("pause_state", 8'(state_o), 8'd6);
        chk("pause_clk", 8'(clk_core_en_o), 8'd0);
        chk("pause_rstn", 8'(rst_n_core_o), 8'd1);
        chk("pause_busy", 8'(busy_o), 8'd0);
        rst_n_req_i = 1'b0;
        tick();
        chk("prst_state", 8'(state_o), 8'd4);
        chk("prst_clk", 8'(clk_core_en_o), 8'd1);
        chk("prst_rstn", 8'(rst_n_core_o), 8'd0);
        chk("prst_busy", 8'(busy_o), 8'd1);
        clk_en_req_i = 1'b1; rst_n_req_i = 1'b1;
        wait_state(3'd3, 20, "prst_back_run");
`else
        // Drain with no idle: times out after IdleT cycles and sets the sticky flag.
        core_idle_i = 1'b0;
        clk_en_req_i = 1'b0;
        tick();
        n = 0;
        while (state_o === 3'd5 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_cycles", 8'(n), 8'(IdleT));
        chk("drain_to_pause", 8'(state_o), 8'd6);
        chk("drain_flag_set", 8'(drain_timeout_o), 8'd1);
        chk("model_pin_flag", 8'(m_flag), 8'd1);
        clk_en_req_i = 1'b1;
        tick();
        chk("flag_kept_pause_run", 8'(drain_timeout_o), 8'd1);
        rst_n_req_i = 1'b0;
        tick();
        rst_n_req_i = 1'b1;
        wait_state(3'd3, 20, "flag_reset_run");
        chk("flag_cleared", 8'(drain_timeout_o), 8'd0);
        // Idle arrives in the third DRAIN cycle.
        clk_en_req_i = 1'b0;
        tick();
        tick();
        tick();
        core_idle_i = 1'b1;
        tick();
        chk("idle_pause", 8'(state_o), 8'd6);
        chk("idle_flag_clear", 8'(drain_timeout_o), 8'd0);
        core_idle_i = 1'b0;
        clk_en_req_i = 1'b1;
        wait_state(3'd3, 5, "idle_back_run");
`endif

        // Asynchronous reset in the middle of RST_REL, then a full restart.
        clk_en_req_i = 1'b0; rst_n_req_i = 1'b0;
        wait_state(3'd0, 30, "to_off");
        clk_en_req_i = 1'b1; rst_n_req_i = 1'b1;
        repeat (3) tick();
        chk("mid_rel_state", 8'(state_o), 8'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_clk", 8'(clk_core_en_o), 8'd0);
        chk("async_rstn", 8'(rst_n_core_o), 8'd0);
        chk("async_busy", 8'(busy_o), 8'd0);
        chk("async_state", 8'(state_o), 8'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        powerup_seq("restart");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
